light_conflict_monitor: RTL and testbench

LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

---
 rtl/lcm_pkg.sv | 35 +++
 rtl/light_conflict_monitor_sec_tick.sv | 31 +++
 rtl/light_conflict_monitor.sv | 181 ++++++++++++++++++
 tb/tb_light_conflict_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcm_pkg.sv
// Shared constants, FSM state type and lamp helpers for the light conflict monitor.
package lcm_pkg;

  // One-hot lamp drive encodings {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Fault codes; a lower number wins when several occur together
  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_ENCODING  = 3'd2;
  localparam logic [2:0] FC_SEQUENCE  = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_FARM_WDOG = 3'd5;

  typedef enum logic {
    ARMED = 1'b0,
    FAULT = 1'b1
  } lcm_state_t;

  // True when exactly one lamp of a road is driven
  function automatic logic is_one_hot(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
  endfunction

  // True when cur is prev held, or the next lamp in the G->Y->R->G cycle
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (cur == prev) ||
           ((prev == LAMP_GRN) && (cur == LAMP_YEL)) ||
           ((prev == LAMP_YEL) && (cur == LAMP_RED)) ||
           ((prev == LAMP_RED) && (cur == LAMP_GRN));
  endfunction

endpackage

// File: rtl/light_conflict_monitor_sec_tick.sv
// sec_tick: CLK_HZ prescaler producing a registered one-cycle pulse once per second.
// clr restarts the second so the first pulse lands a full second after it.
module sec_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  // Count clock cycles and pulse on the last cycle of each second
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor: watches highway/farm lamp drives, latches the first
// (highest-priority) fault, flashes a fail-safe red at 1 Hz while faulted and
// counts latched faults. Define LCM_FARM_WDOG_EN to add the farm-green watchdog
// (fault code 5); without it the watchdog logic is absent.
module light_conflict_monitor
  import lcm_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned MIN_YEL_S  = 3,
  parameter int unsigned MAX_FGRN_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red,
  output logic [7:0] fault_count
);

  localparam int unsigned YEL_LIMIT = MIN_YEL_S * CLK_HZ;
  localparam int unsigned YW        = (YEL_LIMIT > 0) ? $clog2(YEL_LIMIT + 1) : 1;
  localparam logic [YW-1:0] YEL_MAX = YW'(YEL_LIMIT);

  // Reject parameter sets that would collapse counters to zero width
  if ((CLK_HZ == 0) || (MIN_YEL_S == 0) || (MAX_FGRN_S == 0)) begin : g_bad_params
    $error("light_conflict_monitor: CLK_HZ, MIN_YEL_S and MAX_FGRN_S must be non-zero");
  end

  lcm_state_t    state;
  logic [2:0]    prev_highway;
  logic [2:0]    prev_farm;
  logic          prev_valid;
  logic [YW-1:0] yel_cnt_highway;
  logic [YW-1:0] yel_cnt_farm;

  logic          conflict;
  logic          encoding;
  logic          sequence_err;
  logic          short_yel;
  logic          wdog;
  logic [2:0]    det_code;
  logic          enter_fault;
  logic          clear_fault;
  logic          sec_pulse;

`ifdef LCM_FARM_WDOG_EN
  localparam int unsigned WD_LIMIT = MAX_FGRN_S * CLK_HZ;
  localparam int unsigned WW       = $clog2(WD_LIMIT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(WD_LIMIT);

  logic [WW-1:0] grn_cnt_farm;

  // Consecutive farm-green samples, saturating at the watchdog limit
  always_ff @(posedge clk) begin
    if (rst) begin
      grn_cnt_farm <= '0;
    end else if (light_farm != LAMP_GRN) begin
      grn_cnt_farm <= '0;
    end else if (grn_cnt_farm != WD_MAX) begin
      grn_cnt_farm <= grn_cnt_farm + WW'(1);
    end
  end
`endif

  // Classify the current sample and pick the highest-priority fault code
  always_comb begin
    conflict     = (light_highway != LAMP_RED) && (light_farm != LAMP_RED);
    encoding     = !is_one_hot(light_highway) || !is_one_hot(light_farm);
    sequence_err = 1'b0;
    short_yel    = 1'b0;
    wdog         = 1'b0;
    det_code     = FC_NONE;

    if (prev_valid) begin
      sequence_err = !legal_step(prev_highway, light_highway) ||
                     !legal_step(prev_farm, light_farm);
      short_yel    = ((prev_highway == LAMP_YEL) && (light_highway == LAMP_RED) &&
                      (yel_cnt_highway < YEL_MAX)) ||
                     ((prev_farm == LAMP_YEL) && (light_farm == LAMP_RED) &&
                      (yel_cnt_farm < YEL_MAX));
    end

`ifdef LCM_FARM_WDOG_EN
    // The current green sample is one past a full limit of prior greens
    wdog = (light_farm == LAMP_GRN) && (grn_cnt_farm == WD_MAX);
`endif

    if (conflict) begin
      det_code = FC_CONFLICT;
    end else if (encoding) begin
      det_code = FC_ENCODING;
    end else if (sequence_err) begin
      det_code = FC_SEQUENCE;
    end else if (short_yel) begin
      det_code = FC_SHORT_YEL;
    end else if (wdog) begin
      det_code = FC_FARM_WDOG;
    end

    enter_fault = (state == ARMED) && (det_code != FC_NONE);
    clear_fault = (state == FAULT) && fault_clr && !conflict && !encoding;
  end

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .clr (enter_fault),
    .tick(sec_pulse)
  );

  // Sample history and per-road yellow hold counters
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_highway    <= '0;
      prev_farm       <= '0;
      prev_valid      <= 1'b0;
      yel_cnt_highway <= '0;
      yel_cnt_farm    <= '0;
    end else begin
      prev_highway <= light_highway;
      prev_farm    <= light_farm;
      prev_valid   <= !clear_fault;

      if (light_highway != LAMP_YEL) begin
        yel_cnt_highway <= '0;
      end else if (yel_cnt_highway != YEL_MAX) begin
        yel_cnt_highway <= yel_cnt_highway + YW'(1);
      end

      if (light_farm != LAMP_YEL) begin
        yel_cnt_farm <= '0;
      end else if (yel_cnt_farm != YEL_MAX) begin
        yel_cnt_farm <= yel_cnt_farm + YW'(1);
      end
    end
  end

  // ARMED/FAULT state machine with latched code, flasher and fault counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARMED;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      flash_red   <= 1'b0;
      fault_count <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (enter_fault) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= det_code;
            flash_red  <= 1'b1;
            if (fault_count != 8'hFF) begin
              fault_count <= fault_count + 8'd1;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state      <= ARMED;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            flash_red  <= 1'b0;
          end else if (sec_pulse) begin
            flash_red <= ~flash_red;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Testbench for light_conflict_monitor (CLK_HZ=10, MIN_YEL_S=3, MAX_FGRN_S=5).
// Expectations track LCM_FARM_WDOG_EN when the bench is built with it defined.
module tb_light_conflict_monitor;

  localparam int unsigned CLK_HZ     = 10;
  localparam int unsigned MIN_YEL_S  = 3;
  localparam int unsigned MAX_FGRN_S = 5;
  localparam int          YEL_CYC    = MIN_YEL_S * CLK_HZ;
  localparam int          WD_CYC     = MAX_FGRN_S * CLK_HZ;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_highway = 3'b100;
  logic [2:0] light_farm = 3'b100;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;
  logic [7:0] fault_count;

  int checks = 0;
  int failures = 0;

  // Reference model: lamps history, run lengths and latched status as plain ints
  bit         m_fault;
  int         m_code;
  int         m_count;
  logic [2:0] mp_h;
  logic [2:0] mp_f;
  bit         mp_valid;
  int         m_yel_h;
  int         m_yel_f;
  int         m_grn_f;

  light_conflict_monitor #(
    .CLK_HZ    (CLK_HZ),
    .MIN_YEL_S (MIN_YEL_S),
    .MAX_FGRN_S(MAX_FGRN_S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .light_highway(light_highway),
    .light_farm   (light_farm),
    .fault_clr    (fault_clr),
    .fault        (fault),
    .fault_code   (fault_code),
    .flash_red    (flash_red),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [2:0] a, input logic [2:0] b);
    return (a == b) || (a == G && b == Y) || (a == Y && b == R) || (a == R && b == G);
  endfunction

  task automatic model_update(input logic [2:0] h, input logic [2:0] f, input logic c, input logic r);
    bit conf, enc, seq, shorty, wd, cleared;
    int code;
    if (r) begin
      m_fault = 0; m_code = 0; m_count = 0; mp_valid = 0;
      m_yel_h = 0; m_yel_f = 0; m_grn_f = 0;
      return;
    end
    conf   = (h != R) && (f != R);
    enc    = ($countones(h) != 1) || ($countones(f) != 1);
    seq    = mp_valid && (!legal(mp_h, h) || !legal(mp_f, f));
    shorty = mp_valid && ((mp_h == Y && h == R && m_yel_h < YEL_CYC) ||
                          (mp_f == Y && f == R && m_yel_f < YEL_CYC));
    wd = 0;
`ifdef LCM_FARM_WDOG_EN
    wd = (f == G) && (m_grn_f >= WD_CYC);
`endif
    code = conf ? 1 : enc ? 2 : seq ? 3 : shorty ? 4 : wd ? 5 : 0;
    cleared = 0;
    if (!m_fault) begin
      if (code != 0) begin
        m_fault = 1;
        m_code  = code;
        if (m_count < 255) m_count++;
      end
    end else if (c && !conf && !enc) begin
      m_fault = 0;
      m_code  = 0;
      cleared = 1;
    end
    m_yel_h  = (h == Y) ? m_yel_h + 1 : 0;
    m_yel_f  = (f == Y) ? m_yel_f + 1 : 0;
    m_grn_f  = (f == G) ? m_grn_f + 1 : 0;
    mp_h     = h;
    mp_f     = f;
    mp_valid = !cleared;
  endtask

  // Apply one sample for one clock, advance the model, settle just past the edge
  task automatic step(input logic [2:0] h, input logic [2:0] f, input logic c, input logic r);
    @(negedge clk);
    light_highway = h;
    light_farm    = f;
    fault_clr     = c;
    rst           = r;
    @(posedge clk);
    model_update(h, f, c, r);
    #1;
  endtask

  task automatic do_reset();
    step(R, R, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(G, G, 1'b1, 1'b1);
    checks++;
    if ({fault, fault_code, flash_red, fault_count} !== 13'd0) begin
      failures++;
      $display("FAIL reset: fault=%0b code=%0d flash=%0b count=%0d, required all 0",
               fault, fault_code, flash_red, fault_count);
    end
  endtask

  task automatic test_legal_cycle();
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 5; i++)  begin step(G, R, 0, 0); seen |= fault; end
    for (int i = 0; i < 30; i++) begin step(Y, R, 0, 0); seen |= fault; end
    for (int i = 0; i < 10; i++) begin step(R, G, 0, 0); seen |= fault; end
    for (int i = 0; i < 30; i++) begin step(R, Y, 0, 0); seen |= fault; end
    for (int i = 0; i < 5; i++)  begin step(G, R, 0, 0); seen |= fault; end
    checks++;
    if (seen !== 1'b0 || fault_count !== 8'd0) begin
      failures++;
      $display("FAIL legal_cycle: fault_seen=%0b count=%0d, required 0 and 0", seen, fault_count);
    end
  endtask

  task automatic test_short_yellow();
    do_reset();
    for (int i = 0; i < 3; i++)  step(G, R, 0, 0);
    for (int i = 0; i < 29; i++) step(Y, R, 0, 0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL short_yel_pre: fault=%0b, required 0", fault);
    end
    step(R, R, 0, 0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4 || fault_count !== 8'd1) begin
      failures++;
      $display("FAIL short_yel: fault=%0b code=%0d count=%0d, required 1 4 1",
               fault, fault_code, fault_count);
    end
  endtask

  task automatic test_priority_flash();
    int toggles[$];
    logic prev_fl;
    do_reset();
    step(3'b011, G, 0, 0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || flash_red !== 1'b1) begin
      failures++;
      $display("FAIL priority: fault=%0b code=%0d flash=%0b, required 1 1 1",
               fault, fault_code, flash_red);
    end
    prev_fl = flash_red;
    for (int n = 1; n <= 45; n++) begin
      step(3'($urandom), 3'($urandom), 0, 0);
      if (flash_red !== prev_fl) toggles.push_back(n);
      prev_fl = flash_red;
    end
    checks++;
    if (toggles.size() < 3 || toggles[0] < 1 || toggles[0] > CLK_HZ + 1) begin
      failures++;
      $display("FAIL flash_first: toggles=%0d first=%0d, required >=3 and first in 1..%0d",
               toggles.size(), (toggles.size() > 0) ? toggles[0] : -1, CLK_HZ + 1);
    end
    for (int k = 1; k < toggles.size(); k++) begin
      checks++;
      if (toggles[k] - toggles[k-1] != CLK_HZ) begin
        failures++;
        $display("FAIL flash_period: gap=%0d, required %0d", toggles[k] - toggles[k-1], CLK_HZ);
      end
    end
    checks++;
    if (fault_code !== 3'd1) begin
      failures++;
      $display("FAIL code_hold: code=%0d, required 1", fault_code);
    end
  endtask

  task automatic test_sequence_clear();
    do_reset();
    for (int i = 0; i < 3; i++) step(G, R, 0, 0);
    step(R, R, 0, 0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      failures++;
      $display("FAIL seq: fault=%0b code=%0d, required 1 3", fault, fault_code);
    end
    step(G, G, 1, 0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      failures++;
      $display("FAIL clr_blocked: fault=%0b code=%0d, required 1 3", fault, fault_code);
    end
    step(R, R, 1, 0);
    checks++;
    if (fault !== 1'b0 || flash_red !== 1'b0) begin
      failures++;
      $display("FAIL clr: fault=%0b flash=%0b, required 0 0", fault, flash_red);
    end
    step(Y, R, 0, 0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL first_after_clr: fault=%0b code=%0d, required 0", fault, fault_code);
    end
    step(R, R, 0, 0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4 || fault_count !== 8'd2) begin
      failures++;
      $display("FAIL seq_rearmed: fault=%0b code=%0d count=%0d, required 1 4 2",
               fault, fault_code, fault_count);
    end
  endtask

  task automatic test_farm_wdog();
    do_reset();
    for (int i = 0; i < WD_CYC; i++) step(R, G, 0, 0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL wdog_pre: fault=%0b, required 0", fault);
    end
    step(R, G, 0, 0);
    checks++;
`ifdef LCM_FARM_WDOG_EN
    if (fault !== 1'b1 || fault_code !== 3'd5) begin
      failures++;
      $display("FAIL wdog: fault=%0b code=%0d, required 1 5", fault, fault_code);
    end
`else
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL wdog_off: fault=%0b code=%0d, required 0", fault, fault_code);
    end
`endif
  endtask

  task automatic test_reset_in_fault();
    do_reset();
    step(G, G, 0, 0);
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL enter_for_reset: fault=%0b, required 1", fault);
    end
    step(G, G, 1, 1);
    checks++;
    if ({fault, fault_code, flash_red, fault_count} !== 13'd0) begin
      failures++;
      $display("FAIL reset_in_fault: fault=%0b code=%0d flash=%0b count=%0d, required all 0",
               fault, fault_code, flash_red, fault_count);
    end
  endtask

  task automatic test_count_saturate();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(G, G, 0, 0);
      if (fault !== 1'b1) bad++;
      step(R, R, 1, 0);
    end
    checks++;
    if (fault_count !== 8'd255 || bad != 0) begin
      failures++;
      $display("FAIL count_sat: count=%0d missed_entries=%0d, required 255 0", fault_count, bad);
    end
  endtask

  task automatic test_random();
    logic [2:0] ch, cf, hn, fn;
    int r;
    do_reset();
    ch = G;
    cf = R;
    for (int n = 0; n < 3000; n++) begin
      hn = ch;
      fn = cf;
      r = $urandom_range(0, 99);
      if (r >= 97) hn = 3'($urandom);
      else if (r >= 85) hn = (ch == G) ? Y : (ch == Y) ? R : (ch == R) ? G : R;
      r = $urandom_range(0, 99);
      if (r >= 97) fn = 3'($urandom);
      else if (r >= 85) fn = (cf == G) ? Y : (cf == Y) ? R : (cf == R) ? G : R;
      ch = hn;
      cf = fn;
      step(hn, fn, ($urandom_range(0, 7) == 0), 1'b0);
      checks++;
      if (fault !== m_fault || fault_code !== 3'(m_code) || fault_count !== 8'(m_count) ||
          (!m_fault && flash_red !== 1'b0)) begin
        failures++;
        $display("FAIL random[%0d]: fault=%0b code=%0d count=%0d flash=%0b, required %0b %0d %0d (flash 0 if clear)",
                 n, fault, fault_code, fault_count, flash_red, m_fault, m_code, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_short_yellow();
    test_priority_flash();
    test_sequence_clear();
    test_farm_wdog();
    test_reset_in_fault();
    test_count_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
